// File: rtl/fnd_pkg.sv
// Shared constants for the FND tone display: segment patterns ({g,f,e,d,c,b,a},
// active-high), octave numeral table, FSM state encoding and note->segment lookup.
package fnd_pkg;
  localparam logic [6:0] SEG_C     = 7'b0111001;
  localparam logic [6:0] SEG_D     = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_F     = 7'b1110001;
  localparam logic [6:0] SEG_G     = 7'b1111101;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [6:0] SEG_DIGIT [0:7] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111
  };

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    PLAY = ST_PLAY,
    HOLD = ST_HOLD
  } state_t;

  // Note code 0..6 = C,D,E,F,G,A,B
  function automatic logic [6:0] note_seg(input logic [2:0] n);
    case (n)
      3'd0:    note_seg = SEG_C;
      3'd1:    note_seg = SEG_D;
      3'd2:    note_seg = SEG_E;
      3'd3:    note_seg = SEG_F;
      3'd4:    note_seg = SEG_G;
      3'd5:    note_seg = SEG_A;
      3'd6:    note_seg = SEG_B;
      default: note_seg = SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/fnd_scan_ctr.sv
// Scan prescaler and digit-index counter.
//   clk, rst (sync, active-low)
//   idx  : digit currently selected, 0..N_DIGITS-1
//   wrap : high on the last prescaler cycle of a digit slot (idx advances next edge)
module fnd_scan_ctr
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV = 25000,
  parameter int N_DIGITS = 4,
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1,
  localparam int IW = $clog2(N_DIGITS)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [IW-1:0] idx,
  output logic          wrap
);
  logic [CW-1:0] cnt;

  assign wrap = (cnt == CW'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (wrap) begin
      cnt <= '0;
      idx <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/fnd_tone_scan.sv
// Scanned multi-digit 7-segment driver for the piano front panel.
//   clk, rst (sync, active-low)
//   sel        : key bus, bit N_KEYS-1 = C ... bit 0 = B, highest set bit wins
//   octave     : octave number 0-7
//   seg        : {g,f,e,d,c,b,a}, active-high
//   dp         : decimal point, lit on digit 0 while playing
//   com        : digit commons, exactly one at COM_ACTIVE outside reset
//   note_valid : high while a note is playing or being held
module fnd_tone_scan
  import fnd_pkg::*;
#(
  parameter int N_KEYS     = 7,
  parameter int N_DIGITS   = 4,
  parameter int SCAN_DIV   = 25000,
  parameter int HOLD_CYC   = 50000000,
  parameter bit COM_ACTIVE = 1'b0,
  localparam int IW = $clog2(N_DIGITS),
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_KEYS-1:0]   sel,
  input  logic [2:0]          octave,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [N_DIGITS-1:0] com,
  output logic                note_valid
);
  logic [N_KEYS-1:0] sel_r;
  logic [2:0]        oct_r;
  logic              pressed;
  logic [2:0]        key;
  state_t            state;
  logic [2:0]        note;
  logic [2:0]        oct;
  logic [HW-1:0]     hold;
  logic [IW-1:0]     idx;
  logic              unused_wrap;  // slot strobe, not needed by this display path
  logic [6:0]        seg_nxt;
  logic [N_DIGITS-1:0] com_nxt;

  fnd_scan_ctr #(.SCAN_DIV(SCAN_DIV), .N_DIGITS(N_DIGITS)) u_scan (
    .clk (clk),
    .rst (rst),
    .idx (idx),
    .wrap(unused_wrap)
  );

  // Ascending scan: the last (highest) set bit overwrites lower ones.
  assign pressed = |sel_r;
  always_comb begin
    key = 3'd0;
    for (int i = 0; i < N_KEYS; i++)
      if (sel_r[i]) key = 3'(N_KEYS - 1 - i);
  end

  always_comb begin
    seg_nxt = SEG_BLANK;
    if (state == IDLE) begin
      if (idx == IW'(0) || idx == IW'(1)) seg_nxt = SEG_DASH;
    end else if (idx == IW'(0)) begin
      seg_nxt = note_seg(note);
    end else if (idx == IW'(1)) begin
      seg_nxt = SEG_DIGIT[oct];
    end
  end

  always_comb begin
    for (int i = 0; i < N_DIGITS; i++)
      com_nxt[i] = (idx == IW'(i)) ? COM_ACTIVE : ~COM_ACTIVE;
  end

  // FSM plus output registers; seg/dp/com share one edge so no ghosting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sel_r      <= '0;
      oct_r      <= '0;
      state      <= IDLE;
      note       <= '0;
      oct        <= '0;
      hold       <= '0;
      seg        <= SEG_BLANK;
      dp         <= 1'b0;
      com        <= {N_DIGITS{~COM_ACTIVE}};
      note_valid <= 1'b0;
    end else begin
      sel_r      <= sel;
      oct_r      <= octave;
      seg        <= seg_nxt;
      dp         <= (state == PLAY) && (idx == IW'(0));
      com        <= com_nxt;
      note_valid <= (state != IDLE);
      case (state)
        IDLE: if (pressed) begin
          state <= PLAY;
          note  <= key;
          oct   <= oct_r;
        end
        PLAY: if (pressed) begin
          note <= key;
          oct  <= oct_r;
        end else begin
          state <= HOLD;
          hold  <= HW'(HOLD_CYC - 1);
        end
        HOLD: if (pressed) begin  // a press beats a simultaneous timeout
          state <= PLAY;
          note  <= key;
          oct   <= oct_r;
        end else if (hold == '0) begin
          state <= IDLE;
        end else begin
          hold <= hold - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fnd_tone_scan.sv
// Bench for fnd_tone_scan: directed scenarios with literal expectations plus a
// randomized phase, all outputs compared every cycle against a behavioural model.
module tb_fnd_tone_scan;
  localparam int NK = 7, ND = 4, SD = 4, HC = 10;
  localparam logic [6:0] DASH = 7'b1000000;
  // indexed by key bit position: bit0 = B ... bit6 = C
  localparam logic [6:0] KEY_SEG [0:6] = '{
    7'b1111111, 7'b1110111, 7'b1111101, 7'b1110001,
    7'b1111001, 7'b0111111, 7'b0111001
  };
  localparam logic [6:0] DIG_SEG [0:7] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111
  };

  logic clk = 1'b0, rst = 1'b0;
  logic [NK-1:0] sel = '0;
  logic [2:0] octave = '0;
  logic [6:0] seg;
  logic dp, note_valid;
  logic [ND-1:0] com;

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;

  fnd_tone_scan #(.N_KEYS(NK), .N_DIGITS(ND), .SCAN_DIV(SD), .HOLD_CYC(HC),
                  .COM_ACTIVE(1'b0)) dut (
    .clk(clk), .rst(rst), .sel(sel), .octave(octave),
    .seg(seg), .dp(dp), .com(com), .note_valid(note_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 playing, 2 holding. Display slot derived from cycle count.
  int m_mode = 0, m_key = 0, m_oct = 0, m_left = 0, m_cyc = 0, m_octq = 0;
  logic [NK-1:0] m_sel = '0;
  logic [6:0] exp_seg = '0;
  logic exp_dp = 1'b0, exp_nv = 1'b0;
  logic [ND-1:0] exp_com = '1;

  always @(posedge clk) begin
    int slot, top;
    if (!rst) begin
      m_mode = 0; m_key = 0; m_oct = 0; m_left = 0; m_cyc = 0;
      m_sel = '0; m_octq = 0;
      exp_seg = '0; exp_dp = 1'b0; exp_com = '1; exp_nv = 1'b0;
    end else begin
      slot = (m_cyc / SD) % ND;
      if (m_mode == 0) exp_seg = (slot < 2) ? DASH : 7'b0;
      else if (slot == 0) exp_seg = KEY_SEG[m_key];
      else if (slot == 1) exp_seg = DIG_SEG[m_oct];
      else exp_seg = 7'b0;
      exp_dp  = (m_mode == 1) && (slot == 0);
      exp_com = ~(4'b0001 << slot);
      exp_nv  = (m_mode != 0);
      top = -1;
      for (int i = 0; i < NK; i++) if (m_sel[i]) top = i;
      if (top >= 0) begin
        m_mode = 1; m_key = top; m_oct = m_octq;
      end else if (m_mode == 1) begin
        m_mode = 2; m_left = HC - 1;
      end else if (m_mode == 2) begin
        if (m_left == 0) m_mode = 0;
        else m_left--;
      end
      m_cyc++;
      m_sel  = sel;
      m_octq = int'(octave);
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("seg", 32'(seg), 32'(exp_seg));
      chk("dp", 32'(dp), 32'(exp_dp));
      chk("com", 32'(com), 32'(exp_com));
      chk("note_valid", 32'(note_valid), 32'(exp_nv));
    end
  end

  // wait (bounded) for a given common while a note is shown
  task automatic wait_com(input logic [ND-1:0] c, input string nm);
    int n = 0;
    while (!(com === c && note_valid === 1'b1) && n < 60) begin
      tick(1);
      n++;
    end
    if (n >= 60) chk({nm, "_timeout"}, 32'(com), 32'(c));
  endtask

  initial begin
    int cnt, zeros;
    int per [ND];
    // reset
    rst = 1'b0; sel = '0; octave = '0;
    tick(3);
    chk("rst_seg", 32'(seg), 32'd0);
    chk("rst_com", 32'(com), 32'hF);
    chk("rst_nv", 32'(note_valid), 32'd0);
    chk_en = 1'b1;
    rst = 1'b1;
    tick(1);
    chk("idle_dash", 32'(seg), 32'(DASH));
    chk("idle_com0", 32'(com), 32'b1110);
    tick(4); chk("idle_com1", 32'(com), 32'b1101);
    tick(4); chk("idle_com2", 32'(com), 32'b1011);
    tick(4); chk("idle_com3", 32'(com), 32'b0111);

    // single key G, octave 4
    sel = 7'b0000100; octave = 3'd4;
    tick(3);
    chk("play_nv", 32'(note_valid), 32'd1);
    wait_com(4'b1110, "g_d0");
    chk("g_seg", 32'(seg), 32'b1111101);
    chk("g_dp", 32'(dp), 32'd1);
    wait_com(4'b1101, "g_d1");
    chk("oct4_seg", 32'(seg), 32'b1100110);
    wait_com(4'b1011, "g_d2");
    chk("d2_blank", 32'(seg), 32'd0);

    // multi-key: E beats B
    sel = 7'b0010001;
    tick(3);
    wait_com(4'b1110, "e_d0");
    chk("multi_e", 32'(seg), 32'b1111001);

    // hold duration after releasing A
    sel = 7'b0000010;
    tick(4);
    sel = '0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (note_valid) cnt++;
    end
    chk("hold_len", 32'(cnt), 32'(HC + 2));
    chk("hold_end_nv", 32'(note_valid), 32'd0);

    // re-press F exactly as hold count reaches 0
    sel = 7'b0000010;
    tick(4);
    sel = '0;
    tick(10);
    sel = 7'b0001000;
    zeros = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (!note_valid) zeros++;
    end
    chk("repress_no_idle", 32'(zeros), 32'd0);
    wait_com(4'b1110, "f_d0");
    chk("repress_f", 32'(seg), 32'b1110001);

    // reset while playing on digit 2
    wait_com(4'b1011, "mid_d2");
    rst = 1'b0;
    tick(1);
    chk("mid_rst_seg", 32'(seg), 32'd0);
    chk("mid_rst_com", 32'(com), 32'hF);
    chk("mid_rst_nv", 32'(note_valid), 32'd0);
    sel = '0;
    rst = 1'b1;
    tick(1);
    chk("restart_com", 32'(com), 32'b1110);
    chk("restart_dash", 32'(seg), 32'(DASH));

    // scan coverage over two frames
    sel = 7'b1000000; octave = 3'd7;
    tick(5);
    for (int i = 0; i < ND; i++) per[i] = 0;
    for (int k = 0; k < 8 * SD; k++) begin
      tick(1);
      chk("onehot", 32'($countones(~com)), 32'd1);
      for (int i = 0; i < ND; i++) if (!com[i]) per[i]++;
    end
    for (int i = 0; i < ND; i++) chk("com_share", 32'(per[i]), 32'(2 * SD));

    // randomized phase
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 3) == 0) sel = '0;
      else sel = NK'($urandom);
      octave = 3'($urandom);
      if ($urandom_range(0, 40) == 0) begin
        rst = 1'b0;
        tick($urandom_range(1, 2));
        rst = 1'b1;
      end
      tick($urandom_range(1, 16));
    end
    sel = '0;
    tick(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
